// File: rtl/sar_ctrl_mc_pkg.sv
// Shared types and width helpers for the multi-channel SAR ADC controller.
package sar_ctrl_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_HOLD,
        ST_TRIAL,
        ST_ACC
    } state_e;

    // Bits needed to index n items; never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_ctrl_mc_cmp_sync.sv
// Two-flop synchroniser for the differential comparator; the decision is
// "higher" only when the synchronised p is set and n is clear.
module sar_ctrl_mc_cmp_sync (
    input  logic clk_in,
    input  logic rst_in,
    input  logic cmp_p,
    input  logic cmp_n,
    output logic decision
);

    logic [1:0] p_q, p_d;
    logic [1:0] n_q, n_d;

    always_comb begin
        p_d = {p_q[0], cmp_p};
        n_d = {n_q[0], cmp_n};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            p_q <= '0;
            n_q <= '0;
        end else begin
            p_q <= p_d;
            n_q <= n_d;
        end
    end

    assign decision = p_q[1] & ~n_q[1];

endmodule

// File: rtl/sar_ctrl_mc.sv
// Multi-channel SAR ADC controller: sample/hold/bit-trial sequencing of a
// charge-redistribution DAC, 2^k averaging, valid/ready result port.
module sar_ctrl_mc
    import sar_ctrl_mc_pkg::*;
#(
    parameter  int NBITS      = 6,
    parameter  int SAMPLE_CYC = 4,
    parameter  int SETTLE_CYC = 3,
    parameter  int NCH        = 4,
    parameter  int AVG_MAX    = 3,
    localparam int CHW        = idx_w(NCH),
    localparam int KW         = idx_w(AVG_MAX + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start,
    input  logic             cont,
    input  logic [CHW-1:0]   ch_req,
    input  logic [KW-1:0]    avg_log2,
    input  logic             analog_cmp_p,
    input  logic             analog_cmp_n,
    output logic [NBITS-1:0] c,
    output logic             c_gnd,
    output logic             sample_switch,
    output logic [CHW-1:0]   ch_sel,
    output logic             busy,
    output logic [NBITS-1:0] dout,
    output logic [CHW-1:0]   dout_ch,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
);

    localparam int CW = idx_w((SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC);
    localparam int BW = idx_w(NBITS);
    localparam int SW = NBITS + AVG_MAX;
    localparam int NW = AVG_MAX + 1;
    localparam logic [KW-1:0] K_MAX = KW'(AVG_MAX);

    state_e             state_q, state_d;
    logic [CW-1:0]      cyc_q, cyc_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [NBITS-1:0]   c_q, c_d;
    logic               c_gnd_q, c_gnd_d;
    logic               samp_q, samp_d;
    logic [CHW-1:0]     ch_q, ch_d;
    logic [KW-1:0]      k_q, k_d;
    logic [NW-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]      sum_q, sum_d;
    logic [NBITS-1:0]   res_q, res_d;
    logic [CHW-1:0]     res_ch_q, res_ch_d;
    logic               res_ld_q, res_ld_d;
    logic [NBITS-1:0]   dout_q, dout_d;
    logic [CHW-1:0]     dout_ch_q, dout_ch_d;
    logic               dout_valid_q, dout_valid_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;

    logic               decision;
    logic [SW-1:0]      acc_sum;
    logic [NW-1:0]      cnt_nx;

    sar_ctrl_mc_cmp_sync u_cmp_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .cmp_p    (analog_cmp_p),
        .cmp_n    (analog_cmp_n),
        .decision (decision)
    );

    assign acc_sum = sum_q + SW'(c_q);
    assign cnt_nx  = cnt_q + NW'(1);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        cyc_d        = cyc_q;
        bit_d        = bit_q;
        c_d          = c_q;
        c_gnd_d      = c_gnd_q;
        samp_d       = samp_q;
        ch_d         = ch_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        res_d        = res_q;
        res_ch_d     = res_ch_q;
        res_ld_d     = 1'b0;
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cont || start) begin
                    state_d = ST_SAMPLE;
                    ch_d    = cont ? '0 : ch_req;
                    k_d     = (avg_log2 > K_MAX) ? K_MAX : avg_log2;
                    samp_d  = 1'b1;
                    c_gnd_d = 1'b1;
                    c_d     = '0;
                    cyc_d   = '0;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_SAMPLE: begin
                if (cyc_q == CW'(SAMPLE_CYC - 1)) begin
                    state_d = ST_HOLD;
                    samp_d  = 1'b0;
                    c_gnd_d = 1'b0;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_TRIAL;
                bit_d   = BW'(NBITS - 1);
                c_d     = NBITS'(1) << (NBITS - 1);
                cyc_d   = '0;
            end
            ST_TRIAL: begin
                if (cyc_q == CW'(SETTLE_CYC - 1)) begin
                    c_d[bit_q] = decision;
                    cyc_d      = '0;
                    if (bit_q == '0) begin
                        state_d = ST_ACC;
                    end else begin
                        bit_d            = bit_q - BW'(1);
                        c_d[bit_q - 1'b1] = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_ACC: begin
                c_d     = '0;
                c_gnd_d = 1'b1;
                cyc_d   = '0;
                if (cnt_nx < (NW'(1) << k_q)) begin
                    sum_d   = acc_sum;
                    cnt_d   = cnt_nx;
                    state_d = ST_SAMPLE;
                    samp_d  = 1'b1;
                end else begin
                    sum_d    = '0;
                    cnt_d    = '0;
                    res_d    = NBITS'(acc_sum >> k_q);
                    res_ch_d = ch_q;
                    res_ld_d = 1'b1;
                    if (cont) begin
                        ch_d    = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + CHW'(1);
                        state_d = ST_SAMPLE;
                        samp_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Result register: a fresh result always wins over the pending one.
        if (res_ld_q) begin
            dout_d       = res_q;
            dout_ch_d    = res_ch_q;
            dout_valid_d = 1'b1;
            overrun_d    = dout_valid_q && !dout_ready;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_in) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            bit_q        <= '0;
            c_q          <= '0;
            c_gnd_q      <= 1'b1;
            samp_q       <= 1'b0;
            ch_q         <= '0;
            k_q          <= '0;
            cnt_q        <= '0;
            sum_q        <= '0;
            res_q        <= '0;
            res_ch_q     <= '0;
            res_ld_q     <= 1'b0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            bit_q        <= bit_d;
            c_q          <= c_d;
            c_gnd_q      <= c_gnd_d;
            samp_q       <= samp_d;
            ch_q         <= ch_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            res_q        <= res_d;
            res_ch_q     <= res_ch_d;
            res_ld_q     <= res_ld_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign c             = c_q;
    assign c_gnd         = c_gnd_q;
    assign sample_switch = samp_q;
    assign ch_sel        = ch_q;
    assign busy          = busy_q;
    assign dout          = dout_q;
    assign dout_ch       = dout_ch_q;
    assign dout_valid    = dout_valid_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_sar_ctrl_mc.sv
// Self-checking bench: a comparator model with per-conversion target codes, and
// a result-port model that predicts each result's value, channel and arrival edge.
module tb_sar_ctrl_mc;

    localparam int NBITS      = 6;
    localparam int SAMPLE_CYC = 4;
    localparam int SETTLE_CYC = 3;
    localparam int NCH        = 4;
    localparam int AVG_MAX    = 3;
    localparam int CONV_LEN   = SAMPLE_CYC + 1 + NBITS * SETTLE_CYC + 1;
    localparam int MAXCODE    = (1 << NBITS) - 1;

    logic             clk_in = 1'b0;
    logic             rst_in, start, cont, dout_ready;
    logic [1:0]       ch_req;
    logic [1:0]       avg_log2;
    logic             analog_cmp_p, analog_cmp_n;
    logic [NBITS-1:0] c, dout;
    logic             c_gnd, sample_switch, busy, dout_valid, overrun;
    logic [1:0]       ch_sel, dout_ch;

    sar_ctrl_mc #(
        .NBITS(NBITS), .SAMPLE_CYC(SAMPLE_CYC), .SETTLE_CYC(SETTLE_CYC),
        .NCH(NCH), .AVG_MAX(AVG_MAX)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .cont(cont),
        .ch_req(ch_req), .avg_log2(avg_log2),
        .analog_cmp_p(analog_cmp_p), .analog_cmp_n(analog_cmp_n),
        .c(c), .c_gnd(c_gnd), .sample_switch(sample_switch), .ch_sel(ch_sel),
        .busy(busy), .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .overrun(overrun)
    );

    always #5 clk_in = ~clk_in;

    // Comparator: in target mode the DAC voltage is "below input" while c <= target.
    typedef enum {CMP_TGT, CMP_HI, CMP_LO, CMP_EQ} cmp_mode_e;
    cmp_mode_e cmp_mode;
    int        tgt[256];
    int        conv_idx;

    always @(posedge sample_switch) conv_idx++;

    always_comb begin
        analog_cmp_p = 1'b0;
        analog_cmp_n = 1'b1;
        case (cmp_mode)
            CMP_TGT: begin
                analog_cmp_p = (int'(c) <= tgt[(conv_idx < 0) ? 0 : (conv_idx & 255)]);
                analog_cmp_n = !analog_cmp_p;
            end
            CMP_HI: begin analog_cmp_p = 1'b1; analog_cmp_n = 1'b0; end
            CMP_LO: begin analog_cmp_p = 1'b0; analog_cmp_n = 1'b1; end
            CMP_EQ: begin analog_cmp_p = 1'b1; analog_cmp_n = 1'b1; end
            default: ;
        endcase
    end

    // Result-port model driven by a schedule of predicted arrivals.
    typedef struct { int at; int val; int ch; } res_t;
    res_t sched[$];
    int   ecnt = 0;
    bit   m_valid = 0, m_ovr = 0;
    int   m_dout = 0, m_ch = 0;

    always @(posedge clk_in) begin
        ecnt++;
        if (rst_in) begin
            m_valid = 0; m_ovr = 0; m_dout = 0; m_ch = 0;
            sched.delete();
        end else if (sched.size() > 0 && sched[0].at == ecnt) begin
            m_ovr   = m_valid && !dout_ready;
            m_valid = 1;
            m_dout  = sched[0].val;
            m_ch    = sched[0].ch;
            void'(sched.pop_front());
        end else begin
            m_ovr = 0;
            if (m_valid && dout_ready) m_valid = 0;
        end
    end

    int n_chk = 0, n_pass = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecnt);
    endtask

    always @(negedge clk_in) begin
        if (cmp_en) begin
            check("dout_valid", int'(dout_valid), int'(m_valid));
            check("overrun", int'(overrun), int'(m_ovr));
            if (m_valid) begin
                check("dout", int'(dout), m_dout);
                check("dout_ch", int'(dout_ch), m_ch);
            end
        end
    end

    bit rnd_ready = 0;

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run_to(input int e);
        while (ecnt < e) tick();
    endtask

    function automatic int expect_val(input cmp_mode_e mode, input int first, input int k);
        int s = 0;
        if (mode == CMP_HI) return MAXCODE;
        if (mode != CMP_TGT) return 0;
        for (int i = 0; i < (1 << k); i++) s += tgt[first + i];
        return s >> k;
    endfunction

    task automatic single_shot(input int ch, input int k, input cmp_mode_e mode, output int e0);
        conv_idx = -1;
        cmp_mode = mode;
        ch_req   = 2'(ch);
        avg_log2 = 2'(k);
        start    = 1'b1;
        tick();
        e0    = ecnt;
        start = 1'b0;
        sched.push_back('{at: e0 + (1 << k) * CONV_LEN + 1, val: expect_val(mode, 0, k), ch: ch});
        check("busy after start", int'(busy), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", ecnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, lat, rises, ovr_cnt;
        bit prev;
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};

        rst_in = 1'b1; start = 1'b0; cont = 1'b0; ch_req = '0; avg_log2 = '0;
        dout_ready = 1'b1; cmp_mode = CMP_LO; conv_idx = -1;
        repeat (3) tick();
        cmp_en = 1;
        check("rst c", int'(c), 0);
        check("rst c_gnd", int'(c_gnd), 1);
        check("rst sample_switch", int'(sample_switch), 0);
        check("rst ch_sel", int'(ch_sel), 0);
        check("rst busy", int'(busy), 0);
        check("rst dout", int'(dout), 0);
        rst_in = 1'b0;
        tick();

        // Single shot, code 42 on channel 2, latency pinned to 25 edges.
        tgt[0] = 42;
        single_shot(2, 0, CMP_TGT, e0);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (dout_valid) begin lat = ecnt - e0; break; end
        end
        check("latency k=0", lat, 25);
        check("dout code 42", int'(dout), 42);
        check("dout_ch 2", int'(dout_ch), 2);
        tick();
        check("idle after single", int'(busy), 0);

        single_shot(0, 0, CMP_LO, e0);
        run_to(e0 + 26);
        check("fixed low", int'(dout), 0);
        single_shot(3, 0, CMP_HI, e0);
        run_to(e0 + 26);
        check("fixed high", int'(dout), 63);
        single_shot(1, 0, CMP_EQ, e0);
        run_to(e0 + 26);
        check("fixed equal", int'(dout), 0);

        // Averaging 4 conversions of 40..43, result left pending.
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) tgt[i] = 40 + i;
        single_shot(1, 2, CMP_TGT, e0);
        rises = 0; prev = dout_valid;
        while (ecnt < e0 + 4 * CONV_LEN + 6) begin
            tick();
            if (dout_valid && !prev) rises++;
            prev = dout_valid;
        end
        check("avg result", int'(dout), 41);
        check("avg valid rises", rises, 1);

        // Reset held 5 cycles in the middle of a bit trial.
        tgt[0] = 30;
        single_shot(0, 0, CMP_TGT, e0);
        run_to(e0 + 12);
        rst_in = 1'b1;
        tick();
        check("mid rst c", int'(c), 0);
        check("mid rst c_gnd", int'(c_gnd), 1);
        check("mid rst sample_switch", int'(sample_switch), 0);
        check("mid rst busy", int'(busy), 0);
        check("mid rst dout_valid", int'(dout_valid), 0);
        repeat (4) tick();
        rst_in = 1'b0;
        dout_ready = 1'b1;
        tick();

        // Random single shots with a randomly stalling consumer.
        rnd_ready = 1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) tgt[i] = $urandom_range(0, MAXCODE);
            single_shot($urandom_range(0, NCH - 1), $urandom_range(0, AVG_MAX), CMP_TGT, e0);
            run_to(sched[sched.size() - 1].at + 1);
        end
        rnd_ready = 0;
        dout_ready = 1'b1;
        repeat (2) tick();

        // Continuous scan, consumer stalled, cont beats a simultaneous start.
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) tgt[i] = $urandom_range(0, MAXCODE);
        conv_idx = -1; cmp_mode = CMP_TGT; avg_log2 = '0; ch_req = 2'd3;
        cont = 1'b1; start = 1'b1;
        tick();
        e0 = ecnt; start = 1'b0;
        for (int j = 0; j < 6; j++)
            sched.push_back('{at: e0 + CONV_LEN * (j + 1) + 1, val: tgt[j], ch: j % NCH});
        ovr_cnt = 0;
        for (int j = 0; j < 6; j++) begin
            if (j == 5) begin
                run_to(e0 + CONV_LEN * 5 + 12);
                cont = 1'b0;
            end
            run_to(e0 + CONV_LEN * (j + 1) + 1);
            check("scan dout_ch", int'(dout_ch), exp_seq[j]);
            check("scan overrun", int'(overrun), (j >= 1 && j <= 4) ? 1 : 0);
            if (overrun) ovr_cnt++;
            if (j == 4) dout_ready = 1'b1;
        end
        check("scan overrun pulses", ovr_cnt, 4);
        repeat (40) tick();
        check("scan stopped busy", int'(busy), 0);
        check("scan conversions", conv_idx, 5);
        check("schedule drained", sched.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
